// File: rtl/dds_pkg.sv
// Shared DDS definitions: datapath widths, tuning FSM states and the default
// tuning constants used by the controller.
package dds_pkg;

   localparam int unsigned DDS_ACC_W = 32;
   localparam int unsigned DDS_OUT_W = 16;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SWEEP_UP   = 2'd1,
      SWEEP_DOWN = 2'd2
   } tune_state_t;

   localparam logic [DDS_ACC_W-1:0] DEF_STEP_RESET = 32'd42950;
   localparam logic [DDS_ACC_W-1:0] DEF_STEP_MIN   = 32'd1;
   localparam logic [DDS_ACC_W-1:0] DEF_STEP_MAX   = 32'h7FFF_FFFF;
   localparam logic [DDS_ACC_W-1:0] DEF_COARSE_INC = 32'd4294967;
   localparam logic [DDS_ACC_W-1:0] DEF_MICRO_INC  = 32'd42950;
   localparam logic [DDS_ACC_W-1:0] DEF_NANO_INC   = 32'd43;
   localparam logic [DDS_ACC_W-1:0] DEF_PHASE_INC  = 32'h0100_0000;
   localparam logic [DDS_ACC_W-1:0] DEF_SWEEP_INC  = 32'd4295;
   localparam logic [19:0]          DEF_DEBOUNCE   = 20'd500000;
   localparam logic [15:0]          DEF_SWEEP_DIV  = 16'd1000;

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-FF synchronizer, stability counter and a
// single-cycle pulse on an accepted press (releases are accepted silently).
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic [CNT_W-1:0] cnt;

   // Counter runs only while the synchronized level differs from the accepted
   // one; any bounce back to the accepted level restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
            level <= sync2;
            cnt   <= '0;
            press <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/dds_tune_ctrl.sv
// DDS tuning controller: debounced buttons drive a saturating tuning word and
// a wrapping phase offset; an optional triangle sweep runs the tuning word.
module dds_tune_ctrl
   import dds_pkg::*;
#(
   parameter logic [DDS_ACC_W-1:0] STEP_RESET      = DEF_STEP_RESET,
   parameter logic [DDS_ACC_W-1:0] STEP_MIN        = DEF_STEP_MIN,
   parameter logic [DDS_ACC_W-1:0] STEP_MAX        = DEF_STEP_MAX,
   parameter logic [DDS_ACC_W-1:0] COARSE_INC      = DEF_COARSE_INC,
   parameter logic [DDS_ACC_W-1:0] MICRO_INC       = DEF_MICRO_INC,
   parameter logic [DDS_ACC_W-1:0] NANO_INC        = DEF_NANO_INC,
   parameter logic [DDS_ACC_W-1:0] PHASE_INC       = DEF_PHASE_INC,
   parameter logic [19:0]          DEBOUNCE_CYCLES = DEF_DEBOUNCE,
   parameter logic [15:0]          SWEEP_DIV       = DEF_SWEEP_DIV,
   parameter logic [DDS_ACC_W-1:0] SWEEP_INC       = DEF_SWEEP_INC
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Switchadd,
   input  logic                 Switchsub,
   input  logic                 SwitchMicroadd,
   input  logic                 SwitchMicrosub,
   input  logic                 SwitchNanoadd,
   input  logic                 SwitchNanosub,
   input  logic                 phaseadd,
   input  logic                 phasesub,
   input  logic                 sweep_en,
   output logic [DDS_ACC_W-1:0] Step,
   output logic [DDS_ACC_W-1:0] phase,
   output logic                 step_update,
   output logic                 sweeping
);

   localparam int unsigned BTN_N   = 8;
   localparam int unsigned WIDE_W  = DDS_ACC_W + 2;
   localparam int unsigned B_ADD   = 0;
   localparam int unsigned B_SUB   = 1;
   localparam int unsigned B_MADD  = 2;
   localparam int unsigned B_MSUB  = 3;
   localparam int unsigned B_NADD  = 4;
   localparam int unsigned B_NSUB  = 5;
   localparam int unsigned B_PADD  = 6;
   localparam int unsigned B_PSUB  = 7;

   localparam logic signed [WIDE_W-1:0] COARSE_S = $signed({2'b00, COARSE_INC});
   localparam logic signed [WIDE_W-1:0] MICRO_S  = $signed({2'b00, MICRO_INC});
   localparam logic signed [WIDE_W-1:0] NANO_S   = $signed({2'b00, NANO_INC});
   localparam logic signed [WIDE_W-1:0] SWEEP_S  = $signed({2'b00, SWEEP_INC});
   localparam logic signed [WIDE_W-1:0] MIN_S    = $signed({2'b00, STEP_MIN});
   localparam logic signed [WIDE_W-1:0] MAX_S    = $signed({2'b00, STEP_MAX});

   logic [BTN_N-1:0]         raw;
   logic [BTN_N-1:0]         press;
   logic signed [WIDE_W-1:0] delta_c;
   logic signed [WIDE_W-1:0] step_wide_c;
   logic [DDS_ACC_W-1:0]     step_nx;
   logic [DDS_ACC_W-1:0]     phase_nx;
   logic [15:0]              div_cnt;
   logic [15:0]              div_nx;
   logic                     tick_c;
   tune_state_t              state;
   tune_state_t              state_nx;

   function automatic logic [DDS_ACC_W-1:0] clamp_step(input logic signed [WIDE_W-1:0] v);
      if (v < MIN_S)      return STEP_MIN;
      else if (v > MAX_S) return STEP_MAX;
      else                return v[DDS_ACC_W-1:0];
   endfunction

   assign raw = {phasesub, phaseadd, SwitchNanosub, SwitchNanoadd,
                 SwitchMicrosub, SwitchMicroadd, Switchsub, Switchadd};

   for (genvar i = 0; i < BTN_N; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(32'(DEBOUNCE_CYCLES))
      ) u_db (
         .clk  (clk),
         .rst_n(reset),
         .btn  (raw[i]),
         .press(press[i])
      );
   end

   // Net signed step change from all presses landing in the same cycle.
   always_comb begin
      delta_c = '0;
      if (press[B_ADD])  delta_c = delta_c + COARSE_S;
      if (press[B_SUB])  delta_c = delta_c - COARSE_S;
      if (press[B_MADD]) delta_c = delta_c + MICRO_S;
      if (press[B_MSUB]) delta_c = delta_c - MICRO_S;
      if (press[B_NADD]) delta_c = delta_c + NANO_S;
      if (press[B_NSUB]) delta_c = delta_c - NANO_S;
   end

   always_comb begin
      phase_nx = phase;
      if (press[B_PADD] && !press[B_PSUB])      phase_nx = phase + PHASE_INC;
      else if (press[B_PSUB] && !press[B_PADD]) phase_nx = phase - PHASE_INC;
   end

   assign step_wide_c = $signed({2'b00, Step});
   assign tick_c      = (div_cnt == SWEEP_DIV - 16'd1);

   // Next-state, next tuning word and sweep divider.
   always_comb begin
      state_nx = state;
      step_nx  = Step;
      div_nx   = div_cnt;
      case (state)
         IDLE: begin
            step_nx = clamp_step(step_wide_c + delta_c);
            if (sweep_en) begin
               state_nx = SWEEP_UP;
               div_nx   = '0;
            end
         end
         SWEEP_UP: begin
            if (!sweep_en) begin
               state_nx = IDLE;
            end else begin
               div_nx = tick_c ? 16'd0 : div_cnt + 16'd1;
               if (tick_c) begin
                  step_nx = clamp_step(step_wide_c + SWEEP_S);
                  if (step_nx == STEP_MAX) state_nx = SWEEP_DOWN;
               end
            end
         end
         SWEEP_DOWN: begin
            if (!sweep_en) begin
               state_nx = IDLE;
            end else begin
               div_nx = tick_c ? 16'd0 : div_cnt + 16'd1;
               if (tick_c) begin
                  step_nx = clamp_step(step_wide_c - SWEEP_S);
                  if (step_nx == STEP_MIN) state_nx = SWEEP_UP;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         Step        <= STEP_RESET;
         phase       <= '0;
         div_cnt     <= '0;
         step_update <= 1'b0;
         sweeping    <= 1'b0;
      end else begin
         state       <= state_nx;
         Step        <= step_nx;
         phase       <= phase_nx;
         div_cnt     <= div_nx;
         step_update <= (step_nx != Step) || (phase_nx != phase);
         sweeping    <= (state_nx != IDLE);
      end
   end

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Directed bench for dds_tune_ctrl with short debounce/sweep parameters and
// hand-computed tuning word / phase expectations.
module tb_dds_tune_ctrl;

   logic        clk;
   logic        reset;
   logic [7:0]  btns;
   logic        sweep_en;
   logic [31:0] Step;
   logic [31:0] phase;
   logic        step_update;
   logic        sweeping;

   int n_vec;
   int n_err;
   int pulses;

   dds_tune_ctrl #(
      .STEP_RESET     (32'd500),
      .STEP_MIN       (32'd1),
      .STEP_MAX       (32'd1000),
      .COARSE_INC     (32'd300),
      .MICRO_INC      (32'd10),
      .NANO_INC       (32'd1),
      .PHASE_INC      (32'h0100_0000),
      .DEBOUNCE_CYCLES(20'd4),
      .SWEEP_DIV      (16'd3),
      .SWEEP_INC      (32'd100)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .Switchadd     (btns[0]),
      .Switchsub     (btns[1]),
      .SwitchMicroadd(btns[2]),
      .SwitchMicrosub(btns[3]),
      .SwitchNanoadd (btns[4]),
      .SwitchNanosub (btns[5]),
      .phaseadd      (btns[6]),
      .phasesub      (btns[7]),
      .sweep_en      (sweep_en),
      .Step          (Step),
      .phase         (phase),
      .step_update   (step_update),
      .sweeping      (sweeping)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (step_update) pulses++;
      end
   endtask

   task automatic press(input logic [7:0] b);
      pulses = 0;
      btns = b;
      run(8);
      btns = '0;
      run(8);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      btns = '0;
      sweep_en = 1'b0;
      run(2);
      reset = 1'b1;
      pulses = 0;
   endtask

   logic [31:0] sw_exp [7] = '{32'd600, 32'd700, 32'd800, 32'd900, 32'd1000, 32'd900, 32'd800};
   logic [31:0] prev;

   initial begin
      n_vec = 0;
      n_err = 0;
      pulses = 0;
      reset = 1'b0;
      btns = '0;
      sweep_en = 1'b0;
      run(2);
      chk("rst_step", Step, 32'd500);
      chk("rst_phase", phase, 32'd0);
      chk("rst_upd", 32'(step_update), 32'd0);
      chk("rst_sweeping", 32'(sweeping), 32'd0);
      reset = 1'b1;

      // 3-cycle glitch on coarse add is filtered
      pulses = 0;
      btns = 8'h01;
      run(3);
      btns = '0;
      run(10);
      chk("glitch_step", Step, 32'd500);
      chk("glitch_pulses", 32'(pulses), 32'd0);

      // micro add held 10 cycles: single update 7 cycles after the edge
      pulses = 0;
      btns = 8'h04;
      run(7);
      chk("micro_early_step", Step, 32'd500);
      chk("micro_early_pulses", 32'(pulses), 32'd0);
      run(1);
      chk("micro_step", Step, 32'd510);
      chk("micro_upd", 32'(step_update), 32'd1);
      run(2);
      btns = '0;
      run(10);
      chk("micro_hold_step", Step, 32'd510);
      chk("micro_hold_pulses", 32'(pulses), 32'd1);

      // coarse steps with saturation at both ends
      do_reset();
      press(8'h01);
      chk("add1_step", Step, 32'd800);
      chk("add1_pulses", 32'(pulses), 32'd1);
      press(8'h01);
      chk("add2_clamp", Step, 32'd1000);
      chk("add2_pulses", 32'(pulses), 32'd1);
      press(8'h01);
      chk("add3_step", Step, 32'd1000);
      chk("add3_pulses", 32'(pulses), 32'd0);
      press(8'h30);
      chk("nano_cancel_step", Step, 32'd1000);
      chk("nano_cancel_pulses", 32'(pulses), 32'd0);
      press(8'h02);
      chk("sub1_step", Step, 32'd700);
      press(8'h28);
      chk("msub_nsub_step", Step, 32'd689);
      press(8'h09);
      chk("add_msub_step", Step, 32'd979);
      press(8'h02);
      press(8'h02);
      press(8'h02);
      chk("sub_to_79", Step, 32'd79);
      press(8'h02);
      chk("sub_clamp_min", Step, 32'd1);
      chk("sub_clamp_pulses", 32'(pulses), 32'd1);
      press(8'h08);
      chk("msub_at_min", Step, 32'd1);
      chk("msub_at_min_pulses", 32'(pulses), 32'd0);

      // phase wraps modulo 2^32; simultaneous add/sub cancels
      do_reset();
      press(8'h80);
      chk("phsub_wrap", phase, 32'hFF00_0000);
      chk("phsub_pulses", 32'(pulses), 32'd1);
      press(8'h40);
      chk("phadd_back", phase, 32'd0);
      press(8'hC0);
      chk("ph_both", phase, 32'd0);
      chk("ph_both_pulses", 32'(pulses), 32'd0);
      press(8'h40);
      chk("phadd", phase, 32'h0100_0000);
      chk("ph_step_kept", Step, 32'd500);

      // triangle sweep from 500 up to 1000, then down
      do_reset();
      sweep_en = 1'b1;
      run(1);
      chk("sweep_on", 32'(sweeping), 32'd1);
      prev = 32'd500;
      for (int k = 0; k < 7; k++) begin
         pulses = 0;
         run(2);
         chk("sweep_wait_step", Step, prev);
         chk("sweep_wait_pulses", 32'(pulses), 32'd0);
         run(1);
         chk("sweep_step", Step, sw_exp[k]);
         chk("sweep_upd", 32'(step_update), 32'd1);
         prev = sw_exp[k];
      end
      chk("sweep_still_on", 32'(sweeping), 32'd1);
      sweep_en = 1'b0;
      run(1);
      chk("sweep_off", 32'(sweeping), 32'd0);
      pulses = 0;
      run(6);
      chk("sweep_hold_step", Step, 32'd800);
      chk("sweep_hold_pulses", 32'(pulses), 32'd0);

      // reset mid-sweep with a held button
      do_reset();
      press(8'h40);
      chk("pre_rst_phase", phase, 32'h0100_0000);
      sweep_en = 1'b1;
      btns = 8'h04;
      run(8);
      chk("pre_rst_step", Step, 32'd700);
      reset = 1'b0;
      #2;
      chk("mid_rst_step", Step, 32'd500);
      chk("mid_rst_phase", phase, 32'd0);
      chk("mid_rst_sweeping", 32'(sweeping), 32'd0);
      chk("mid_rst_upd", 32'(step_update), 32'd0);
      sweep_en = 1'b0;
      run(3);
      reset = 1'b1;
      pulses = 0;
      run(7);
      chk("post_rst_early", Step, 32'd500);
      chk("post_rst_early_pulses", 32'(pulses), 32'd0);
      run(1);
      chk("post_rst_step", Step, 32'd510);
      chk("post_rst_upd", 32'(step_update), 32'd1);
      run(10);
      chk("post_rst_hold", Step, 32'd510);
      chk("post_rst_pulses", 32'(pulses), 32'd1);
      btns = '0;
      run(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dds_tune_ctrl.md
# dds_tune_ctrl

Tuning controller for the DDS core. It turns the frequency-step and phase push-buttons into a clean, clock-synchronous 32-bit frequency tuning word (`Step`) and a 32-bit phase offset (`phase`), both fed to every waveform generator. It debounces all buttons, applies saturating coarse/micro/nano step changes, and runs an optional autonomous triangle frequency sweep. It replaces button-clocked step logic with a single-clock design.

## Interface
- `STEP_RESET`, 32'd42950: `Step` value after reset.
- `STEP_MIN`, 32'd1: lower saturation bound for `Step`.
- `STEP_MAX`, 32'h7FFF_FFFF: upper saturation bound for `Step`.
- `COARSE_INC`, 32'd4294967: step delta for `Switchadd`/`Switchsub`.
- `MICRO_INC`, 32'd42950: step delta for `SwitchMicroadd`/`SwitchMicrosub`.
- `NANO_INC`, 32'd43: step delta for `SwitchNanoadd`/`SwitchNanosub`.
- `PHASE_INC`, 32'h0100_0000: phase delta per phase button press.
- `DEBOUNCE_CYCLES`, 20'd500000: number of cycles a button level must stay stable before it is accepted.
- `SWEEP_DIV`, 16'd1000: number of cycles between sweep updates.
- `SWEEP_INC`, 32'd4295: step delta per sweep update.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Switchadd`, `Switchsub`, `SwitchMicroadd`, `SwitchMicrosub`, `SwitchNanoadd`, `SwitchNanosub` in 1 each: raw asynchronous step buttons, active-high.
- `phaseadd`, `phasesub` in 1 each: raw asynchronous phase buttons, active-high.
- `sweep_en` in 1: level input; when high, the block runs the frequency sweep.
- `Step` out 32: frequency tuning word (registered).
- `phase` out 32: phase offset (registered).
- `step_update` out 1: one-cycle pulse in the same cycle that `Step` or `phase` takes a new value.
- `sweeping` out 1: high while the FSM is in SWEEP_UP or SWEEP_DOWN.

## Operation
- **Button conditioning:** each button input passes through a 2-FF synchronizer, then a stability counter.
  - The counter resets on any change of the synchronized level.
  - When the level has been stable for `DEBOUNCE_CYCLES` cycles, the debounced level updates.
  - A debounced 0→1 transition produces a one-cycle press pulse. Releases produce no pulse.
- **Manual step update (FSM in IDLE):**
  - Compute delta = sum of the signed increments for all press pulses in the same cycle (add = +INC, sub = −INC).
  - Do the arithmetic in 34-bit signed, then clamp to [`STEP_MIN`, `STEP_MAX`].
  - Simultaneous add and sub of the same granularity cancel each other.
  - If the clamped result equals the current `Step`, there is no `step_update` pulse.
- **Phase update:** `phase` += `PHASE_INC` on a `phaseadd` pulse and −= `PHASE_INC` on a `phasesub` pulse.
  - Phase arithmetic wraps modulo 2^32.
  - Both pulses in the same cycle produce no change.
  - Phase updates are accepted in every FSM state.
- **FSM states:**
  - IDLE: sweep is off; step buttons are active.
  - SWEEP_UP: while `sweep_en` is high, on each tick `Step` = min(`Step` + `SWEEP_INC`, `STEP_MAX`). When `Step` reaches `STEP_MAX`, go to SWEEP_DOWN.
  - SWEEP_DOWN: on each tick `Step` = max(`Step` − `SWEEP_INC`, `STEP_MIN`). When `Step` reaches `STEP_MIN`, go to SWEEP_UP.
  - Transitions: IDLE→SWEEP_UP when `sweep_en` is high. Any state→IDLE when `sweep_en` is low; `Step` holds its current value.
  - Step-button pulses during a sweep are discarded, not queued.
- **Sweep tick:** a divider counts 0..`SWEEP_DIV`−1 and produces a tick at terminal count. The divider is cleared on entry to SWEEP_UP from IDLE.
- **Reset values:** `Step` = `STEP_RESET`; `phase` = 0; `step_update` = 0; `sweeping` = 0; FSM = IDLE. All debounced levels = 0 and all counters = 0.

## Timing
- A button edge is accepted at cycle 0. The press pulse appears at cycle 2 + `DEBOUNCE_CYCLES`. `Step`/`phase` change at the next edge, together with `step_update`.
- Glitches shorter than `DEBOUNCE_CYCLES` produce no pulse.
- The first sweep update occurs `SWEEP_DIV` cycles after entering SWEEP_UP, then every `SWEEP_DIV` cycles after that.
- `sweeping` is registered and changes in the same cycle as the FSM state.
- `sweep_en` is treated as synchronous to `clk`; the source must drive it that way.
- Reset asserted mid-debounce or mid-sweep: all state returns to reset values immediately. No pulse is generated on release of reset, even if a button is held; a held button counts only after the debounce period.
- A `phase` update and a sweep tick in the same cycle are both applied, with a single `step_update` pulse.

## Structure
- Shared package `dds_pkg` holds:
  - the width constants `DDS_ACC_W`=32 and `DDS_OUT_W`=16;
  - the FSM enum `tune_state_t` (IDLE, SWEEP_UP, SWEEP_DOWN);
  - the default increment constants.
- Sub-module `btn_debounce`, parameterized by `DEBOUNCE_CYCLES`, contains the synchronizer, stability counter and press-pulse output. It is instantiated 8 times.
- Step arithmetic, phase arithmetic, sweep divider and FSM sit in the top level.

## Test plan
- Use `DEBOUNCE_CYCLES`=4, `SWEEP_DIV`=3, `SWEEP_INC`=100, `STEP_MIN`=1, `STEP_MAX`=1000, `STEP_RESET`=500, `MICRO_INC`=10, `NANO_INC`=1, `COARSE_INC`=300.
- Hold `SwitchMicroadd` for 10 cycles → `Step` goes 500→510 exactly once, with one `step_update` pulse 7 cycles after the edge.
- Apply a 3-cycle glitch on `Switchadd` → `Step` stays at 500 and `step_update` never pulses.
- Press `Switchadd` twice → 800, then clamps to 1000. A third press leaves 1000 with no pulse. Pressing `SwitchNanoadd` and `SwitchNanosub` together leaves 1000.
- `phasesub` from reset → `phase` = 32'hFF00_0000 (wraps).
- Set `sweep_en`=1 from `Step`=500 → 600, 700, …, 1000 at 3-cycle intervals, then 900 (down). Dropping `sweep_en` at 800 holds 800 and `sweeping` goes to 0.
- Assert `reset` during a sweep with `SwitchMicroadd` held → `Step`=500, `phase`=0, FSM = IDLE. After release, one press is accepted only after the debounce period.
